// File: rtl/axi4_switch_demux_if.sv
// Stream bundle for the 1:2 demux: one slave input stream, two master output streams.
// The slave modport is the demux's view; master is the view of the surrounding fabric.
interface axi4_switch_demux_if #(
    parameter int TDATA_L = 512,
    parameter int TUSER_L = 81,
    parameter int TKEEP_L = 16
);
    logic [TDATA_L-1:0] axi_s0_tdata_i;
    logic [TUSER_L-1:0] axi_s0_tuser_i;
    logic               axi_s0_tlast_i;
    logic [TKEEP_L-1:0] axi_s0_tkeep_i;
    logic               axi_s0_tvalid_i;
    logic               axi_s0_tready_o;

    logic [TDATA_L-1:0] axi_m0_tdata_o;
    logic [TUSER_L-1:0] axi_m0_tuser_o;
    logic               axi_m0_tlast_o;
    logic [TKEEP_L-1:0] axi_m0_tkeep_o;
    logic               axi_m0_tvalid_o;
    logic               axi_m0_tready_i;

    logic [TDATA_L-1:0] axi_m1_tdata_o;
    logic [TUSER_L-1:0] axi_m1_tuser_o;
    logic               axi_m1_tlast_o;
    logic [TKEEP_L-1:0] axi_m1_tkeep_o;
    logic               axi_m1_tvalid_o;
    logic               axi_m1_tready_i;

    modport slave (
        input  axi_s0_tdata_i, axi_s0_tuser_i, axi_s0_tlast_i, axi_s0_tkeep_i, axi_s0_tvalid_i,
        output axi_s0_tready_o,
        output axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tlast_o, axi_m0_tkeep_o, axi_m0_tvalid_o,
        input  axi_m0_tready_i,
        output axi_m1_tdata_o, axi_m1_tuser_o, axi_m1_tlast_o, axi_m1_tkeep_o, axi_m1_tvalid_o,
        input  axi_m1_tready_i
    );

    modport master (
        output axi_s0_tdata_i, axi_s0_tuser_i, axi_s0_tlast_i, axi_s0_tkeep_i, axi_s0_tvalid_i,
        input  axi_s0_tready_o,
        input  axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tlast_o, axi_m0_tkeep_o, axi_m0_tvalid_o,
        output axi_m0_tready_i,
        input  axi_m1_tdata_o, axi_m1_tuser_o, axi_m1_tlast_o, axi_m1_tkeep_o, axi_m1_tvalid_o,
        output axi_m1_tready_i
    );
endinterface

// File: rtl/axi4_switch_demux.sv
// Two-entry FIFO used as the registered output stage of each demux port.
// Latency: 1 cycle push to head. Backpressure: full flag only; caller never pushes when full.
module axi4_switch_demux_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         vld,
    output logic         full
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign vld      = (count != 2'd0);
    assign full     = (count == 2'd2);
endmodule

// 1:2 AXI4-Stream packet demux steering whole packets by a tuser route bit; drops to suppressed ports.
// Latency: 1 cycle input handshake to output valid; full rate with both outputs ready.
// Backpressure: input tready follows only the target FIFO's fullness; dropped beats are always accepted.
module axi4_switch_demux #(
    parameter int TDATA_L    = 512,
    parameter int TUSER_L    = 81,
    parameter int TKEEP_L    = 16,
    parameter int ROUTE_BIT  = 0,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            m_dest_supress,
    axi4_switch_demux_if.slave    axis,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);
    typedef struct packed {
        logic [TDATA_L-1:0] tdata;
        logic [TUSER_L-1:0] tuser;
        logic [TKEEP_L-1:0] tkeep;
        logic               tlast;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                state_q, state_d;
    logic                  dest_q, dest_d;
    logic                  route;
    logic                  in_rdy;
    logic                  fire;
    logic                  cnt_inc;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            full;
    logic [1:0]            out_vld;
    beat_t                 in_beat;
    beat_t                 m0_beat, m1_beat;
    logic [DROP_CNT_W-1:0] drop_cnt;

    assign in_beat = '{tdata: axis.axi_s0_tdata_i,
                       tuser: axis.axi_s0_tuser_i,
                       tkeep: axis.axi_s0_tkeep_i,
                       tlast: axis.axi_s0_tlast_i};
    assign route   = axis.axi_s0_tuser_i[ROUTE_BIT];

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        in_rdy  = 1'b0;
        push    = 2'b00;
        cnt_inc = 1'b0;

        case (state_q)
            IDLE:    in_rdy = m_dest_supress[route] | ~full[route];
            FWD:     in_rdy = ~full[dest_q];
            DROP:    in_rdy = 1'b1;
            default: in_rdy = 1'b0;
        endcase

        // Held in reset the input is never ready, so no beat can slip into a FIFO.
        fire = axis.axi_s0_tvalid_i & in_rdy & rst_n;

        if (fire) begin
            case (state_q)
                IDLE: begin
                    if (m_dest_supress[route]) begin
                        if (in_beat.tlast) cnt_inc = 1'b1;
                        else               state_d = DROP;
                    end else begin
                        push[route] = 1'b1;
                        dest_d      = route;
                        if (!in_beat.tlast) state_d = FWD;
                    end
                end
                FWD: begin
                    push[dest_q] = 1'b1;
                    if (in_beat.tlast) state_d = IDLE;
                end
                DROP: begin
                    if (in_beat.tlast) begin
                        cnt_inc = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (cnt_inc && (drop_cnt != {DROP_CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end

    assign pop[0] = out_vld[0] & axis.axi_m0_tready_i;
    assign pop[1] = out_vld[1] & axis.axi_m1_tready_i;

    axi4_switch_demux_fifo2 #(.W(BEAT_W)) u_fifo_m0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push[0]),
        .push_dat (in_beat),
        .pop      (pop[0]),
        .head_dat (m0_beat),
        .vld      (out_vld[0]),
        .full     (full[0])
    );

    axi4_switch_demux_fifo2 #(.W(BEAT_W)) u_fifo_m1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push[1]),
        .push_dat (in_beat),
        .pop      (pop[1]),
        .head_dat (m1_beat),
        .vld      (out_vld[1]),
        .full     (full[1])
    );

    assign axis.axi_s0_tready_o = in_rdy & rst_n;

    assign axis.axi_m0_tdata_o  = m0_beat.tdata;
    assign axis.axi_m0_tuser_o  = m0_beat.tuser;
    assign axis.axi_m0_tkeep_o  = m0_beat.tkeep;
    assign axis.axi_m0_tlast_o  = m0_beat.tlast;
    assign axis.axi_m0_tvalid_o = out_vld[0];

    assign axis.axi_m1_tdata_o  = m1_beat.tdata;
    assign axis.axi_m1_tuser_o  = m1_beat.tuser;
    assign axis.axi_m1_tkeep_o  = m1_beat.tkeep;
    assign axis.axi_m1_tlast_o  = m1_beat.tlast;
    assign axis.axi_m1_tvalid_o = out_vld[1];

    assign drop_cnt_o = drop_cnt;
endmodule

// File: tb/tb_axi4_switch_demux.sv
// Bench for axi4_switch_demux: directed scenarios plus randomized packets against a packet-level model.
// The drop counter is narrowed so saturation is reachable in a short run.
module tb_axi4_switch_demux;
    localparam int TD = 512;
    localparam int TU = 81;
    localparam int TK = 16;
    localparam int DW = 4;
    localparam int DROP_MAX = (1 << DW) - 1;

    typedef struct packed {
        logic [TD-1:0] d;
        logic [TU-1:0] u;
        logic [TK-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    sup;
    logic [DW-1:0] drop_cnt;

    axi4_switch_demux_if #(.TDATA_L(TD), .TUSER_L(TU), .TKEEP_L(TK)) bus ();

    axi4_switch_demux #(
        .TDATA_L(TD), .TUSER_L(TU), .TKEEP_L(TK), .ROUTE_BIT(0), .DROP_CNT_W(DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m_dest_supress (sup),
        .axis           (bus),
        .drop_cnt_o     (drop_cnt)
    );

    always #5 clk = ~clk;

    beat_t q0[$];
    beat_t q1[$];
    beat_t g0, g1;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    exp_drop = 0;
    bit    rand_rdy = 1'b0;

    // Output monitor: every handshake on a port must match the oldest beat expected there.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.axi_m0_tvalid_o && bus.axi_m0_tready_i) begin
                g0 = {bus.axi_m0_tdata_o, bus.axi_m0_tuser_o, bus.axi_m0_tkeep_o, bus.axi_m0_tlast_o};
                n_cmp++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL m0_unexpected: got tag %h last %0b, required no beat", g0.d[31:0], g0.l);
                end else begin
                    if (g0 !== q0[0]) begin
                        n_fail++;
                        $display("FAIL m0_beat: got tag %h last %0b, required tag %h last %0b",
                                 g0.d[31:0], g0.l, q0[0].d[31:0], q0[0].l);
                    end
                    void'(q0.pop_front());
                end
            end
            if (bus.axi_m1_tvalid_o && bus.axi_m1_tready_i) begin
                g1 = {bus.axi_m1_tdata_o, bus.axi_m1_tuser_o, bus.axi_m1_tkeep_o, bus.axi_m1_tlast_o};
                n_cmp++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL m1_unexpected: got tag %h last %0b, required no beat", g1.d[31:0], g1.l);
                end else begin
                    if (g1 !== q1[0]) begin
                        n_fail++;
                        $display("FAIL m1_beat: got tag %h last %0b, required tag %h last %0b",
                                 g1.d[31:0], g1.l, q1[0].d[31:0], q1[0].l);
                    end
                    void'(q1.pop_front());
                end
            end
        end
    end

    function automatic beat_t mk_beat(input logic [31:0] tag, input logic rb, input logic last);
        beat_t b;
        for (int i = 0; i < TD / 32; i++) b.d[i*32 +: 32] = $urandom;
        b.d[31:0] = tag;
        b.u = TU'({$urandom, $urandom, $urandom});
        b.u[0] = rb;
        b.k = TK'($urandom);
        b.l = last;
        return b;
    endfunction

    function automatic logic port_vld(input int p);
        return (p == 0) ? bus.axi_m0_tvalid_o : bus.axi_m1_tvalid_o;
    endfunction

    function automatic logic [31:0] port_tag(input int p);
        return (p == 0) ? bus.axi_m0_tdata_o[31:0] : bus.axi_m1_tdata_o[31:0];
    endfunction

    task automatic drive(input beat_t b);
        bus.axi_s0_tdata_i  = b.d;
        bus.axi_s0_tuser_i  = b.u;
        bus.axi_s0_tkeep_i  = b.k;
        bus.axi_s0_tlast_i  = b.l;
        bus.axi_s0_tvalid_i = 1'b1;
    endtask

    task automatic rand_readies();
        if (rand_rdy) begin
            bus.axi_m0_tready_i = ($urandom_range(0, 3) != 0);
            bus.axi_m1_tready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic expect_beat(input beat_t b, input int port);
        if (port == 0) q0.push_back(b);
        else if (port == 1) q1.push_back(b);
        else if (b.l && exp_drop < DROP_MAX) exp_drop++;
    endtask

    // port: 0/1 = forwarded to that output, 2 = dropped.
    task automatic send_beat(input beat_t b, input int port);
        int waitc;
        waitc = 0;
        drive(b);
        forever begin
            @(negedge clk);
            if (bus.axi_s0_tready_o === 1'b1) break;
            waitc++;
            if (waitc > 500) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: got tready 0 for %0d cycles, required 1", waitc);
                bus.axi_s0_tvalid_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
            rand_readies();
        end
        @(posedge clk); #1;
        bus.axi_s0_tvalid_i = 1'b0;
        expect_beat(b, port);
        rand_readies();
    endtask

    task automatic send_pkt(input int len, input logic dest, input logic [31:0] tag);
        int port;
        port = sup[dest] ? 2 : int'(dest);
        for (int i = 0; i < len; i++)
            send_beat(mk_beat(tag + i, (i == 0) ? dest : 1'($urandom), (i == len - 1)), port);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0 || drop_cnt !== exp_drop[DW-1:0]) begin
            n_fail++;
            $display("FAIL %s_drain: got q0=%0d q1=%0d drop=%0d, required 0 0 %0d",
                     name, q0.size(), q1.size(), drop_cnt, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sup = 2'b00;
        bus.axi_s0_tvalid_i = 1'b0;
        bus.axi_s0_tdata_i = '0; bus.axi_s0_tuser_i = '0; bus.axi_s0_tkeep_i = '0; bus.axi_s0_tlast_i = 1'b0;
        bus.axi_m0_tready_i = 1'b1;
        bus.axi_m1_tready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.axi_s0_tready_o !== 1'b0 || bus.axi_m0_tvalid_o !== 1'b0 || bus.axi_m1_tvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got tready %b v0 %b v1 %b, required 0 0 0",
                     bus.axi_s0_tready_o, bus.axi_m0_tvalid_o, bus.axi_m1_tvalid_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.axi_s0_tready_o !== 1'b1 || bus.axi_m0_tvalid_o !== 1'b0 ||
            bus.axi_m1_tvalid_o !== 1'b0 || drop_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got tready %b v0 %b v1 %b drop %0d, required 1 0 0 0",
                     bus.axi_s0_tready_o, bus.axi_m0_tvalid_o, bus.axi_m1_tvalid_o, drop_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        send_beat(mk_beat(32'hA0010001, 1'b0, 1'b1), 0);
        @(negedge clk);
        n_cmp++;
        if (bus.axi_m0_tvalid_o !== 1'b1 || bus.axi_m0_tdata_o[31:0] !== 32'hA0010001 || bus.axi_m1_tvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_m0: got v0 %b tag %h v1 %b, required 1 a0010001 0",
                     bus.axi_m0_tvalid_o, bus.axi_m0_tdata_o[31:0], bus.axi_m1_tvalid_o);
        end
        @(posedge clk); #1;
        send_beat(mk_beat(32'hA0020001, 1'b1, 1'b1), 1);
        @(negedge clk);
        n_cmp++;
        if (bus.axi_m1_tvalid_o !== 1'b1 || bus.axi_m1_tdata_o[31:0] !== 32'hA0020001 || bus.axi_m0_tvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_m1: got v1 %b tag %h v0 %b, required 1 a0020001 0",
                     bus.axi_m1_tvalid_o, bus.axi_m1_tdata_o[31:0], bus.axi_m0_tvalid_o);
        end
        idle(4);
        check_drained("single");
    endtask

    task automatic test_multi_beat_lock();
        send_beat(mk_beat(32'hA0050001, 1'b1, 1'b0), 1);
        send_beat(mk_beat(32'hA0050002, 1'b0, 1'b0), 1);
        send_beat(mk_beat(32'hA0050003, 1'b0, 1'b1), 1);
        idle(4);
        check_drained("lock");
    endtask

    task automatic test_backpressure();
        beat_t bc, bd;
        int lowc;
        bus.axi_m0_tready_i = 1'b0;
        send_beat(mk_beat(32'hA00B000A, 1'b0, 1'b0), 0);
        send_beat(mk_beat(32'hA00B000B, 1'b0, 1'b0), 0);
        bc = mk_beat(32'hA00B000C, 1'b0, 1'b0);
        bd = mk_beat(32'hA00B000D, 1'b1, 1'b1);
        drive(bc);
        lowc = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.axi_s0_tready_o === 1'b0) lowc++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (lowc != 4 || bus.axi_m0_tvalid_o !== 1'b1 || bus.axi_m0_tdata_o[31:0] !== 32'hA00B000A) begin
            n_fail++;
            $display("FAIL bp_stall: got low cycles %0d v0 %b head %h, required 4 1 a00b000a",
                     lowc, bus.axi_m0_tvalid_o, bus.axi_m0_tdata_o[31:0]);
        end
        bus.axi_m0_tready_i = 1'b1;
        send_beat(bc, 0);
        send_beat(bd, 0);
        idle(4);
        check_drained("bp");
    endtask

    task automatic test_suppression();
        sup = 2'b10;
        for (int i = 0; i < 2; i++) begin
            drive(mk_beat(32'hA0070001 + i, (i == 0) ? 1'b1 : 1'b0, (i == 1)));
            @(negedge clk);
            n_cmp++;
            if (bus.axi_s0_tready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL sup_ready beat %0d: got %b, required 1", i, bus.axi_s0_tready_o);
            end
            @(posedge clk); #1;
            bus.axi_s0_tvalid_i = 1'b0;
            if (i == 1) exp_drop++;
            @(negedge clk);
            n_cmp++;
            if (bus.axi_m1_tvalid_o !== 1'b0 || drop_cnt !== exp_drop[DW-1:0]) begin
                n_fail++;
                $display("FAIL sup_drop beat %0d: got v1 %b drop %0d, required 0 %0d",
                         i, bus.axi_m1_tvalid_o, drop_cnt, exp_drop);
            end
            @(posedge clk); #1;
        end
        send_beat(mk_beat(32'hA0080001, 1'b0, 1'b0), 0);
        sup = 2'b01;
        send_beat(mk_beat(32'hA0080002, 1'b1, 1'b0), 0);
        send_beat(mk_beat(32'hA0080003, 1'b0, 1'b1), 0);
        sup = 2'b00;
        idle(4);
        check_drained("sup");
    endtask

    task automatic test_full_throughput();
        beat_t b[20];
        int pp;
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) begin
                b[k] = mk_beat(32'hA0100000 + k, k[0], 1'b1);
                drive(b[k]);
            end else begin
                bus.axi_s0_tvalid_i = 1'b0;
            end
            @(negedge clk);
            if (k < 20) begin
                n_cmp++;
                if (bus.axi_s0_tready_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tput_ready k=%0d: got %b, required 1", k, bus.axi_s0_tready_o);
                end
            end
            if (k > 0) begin
                pp = (k - 1) % 2;
                n_cmp++;
                if (port_vld(pp) !== 1'b1 || port_tag(pp) !== b[k-1].d[31:0] || port_vld(1 - pp) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tput_latency k=%0d: got v%0d %b tag %h other %b, required 1 %h 0",
                             k - 1, pp, port_vld(pp), port_tag(pp), port_vld(1 - pp), b[k-1].d[31:0]);
                end
            end
            if (k < 20) begin
                @(posedge clk); #1;
                expect_beat(b[k], k % 2);
            end
        end
        idle(4);
        check_drained("tput");
    endtask

    task automatic test_saturation();
        sup = 2'b11;
        for (int i = 0; i < DROP_MAX + 2; i++) send_pkt(1, 1'($urandom), 32'hA0200000 + i);
        sup = 2'b00;
        idle(2);
        n_cmp++;
        if (drop_cnt !== DW'(DROP_MAX)) begin
            n_fail++;
            $display("FAIL drop_saturate: got %0d, required %0d", drop_cnt, DROP_MAX);
        end
        check_drained("sat");
    endtask

    task automatic test_reset_mid_packet();
        send_beat(mk_beat(32'hA0060001, 1'b0, 1'b0), 0);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        exp_drop = 0;
        drive(mk_beat(32'hA0060002, 1'b0, 1'b0));
        @(negedge clk);
        n_cmp++;
        if (bus.axi_s0_tready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ready: got %b, required 0", bus.axi_s0_tready_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.axi_s0_tvalid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.axi_m0_tvalid_o !== 1'b0 || bus.axi_m1_tvalid_o !== 1'b0 || drop_cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got v0 %b v1 %b drop %0d, required 0 0 0",
                     bus.axi_m0_tvalid_o, bus.axi_m1_tvalid_o, drop_cnt);
        end
        @(posedge clk); #1;
        send_beat(mk_beat(32'hA0090001, 1'b1, 1'b1), 1);
        @(negedge clk);
        n_cmp++;
        if (bus.axi_m1_tvalid_o !== 1'b1 || bus.axi_m1_tdata_o[31:0] !== 32'hA0090001 || bus.axi_m0_tvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_route: got v1 %b tag %h v0 %b, required 1 a0090001 0",
                     bus.axi_m1_tvalid_o, bus.axi_m1_tdata_o[31:0], bus.axi_m0_tvalid_o);
        end
        idle(4);
        check_drained("rst_mid");
    endtask

    task automatic test_random();
        rand_rdy = 1'b1;
        for (int p = 0; p < 60; p++) begin
            sup[0] = ($urandom_range(0, 3) == 0);
            sup[1] = ($urandom_range(0, 3) == 0);
            send_pkt($urandom_range(1, 4), 1'($urandom), 32'hB0000000 + (p << 8));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; rand_readies(); end
        end
        rand_rdy = 1'b0;
        sup = 2'b00;
        bus.axi_m0_tready_i = 1'b1;
        bus.axi_m1_tready_i = 1'b1;
        idle(8);
        check_drained("random");
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat_lock();
        test_backpressure();
        test_suppression();
        test_full_throughput();
        test_saturation();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by 2000000, required summary");
        $fatal(1, "watchdog expired");
    end
endmodule
